seq_frame_tx: RTL
=================

SEQ_FRAME_TX -- requirements
Module: seq_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits (legal range 1..16).
REQ-002 Parameter SYNC, default 4'b1001, 4-bit sync marker sent first, MSB first.
REQ-003 Parameter PARITY_EN, default 1: 1 appends an even-parity bit after the payload, 0 omits it.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port start  input  1  frame request, sampled on rising clk edges.
REQ-007 Port din  input  DATA_W  payload, sampled only on the edge that accepts start.
REQ-008 Port ready  output  1  high when a start will be accepted on the next edge.
REQ-009 Port out  output  1  serial bit stream, one bit per clock.
REQ-010 Port busy  output  1  high while out carries a frame bit.
REQ-011 Port done  output  1  one-cycle pulse marking frame completion.

Function
REQ-012 FSM states SHALL be IDLE, SYNC, DATA, PAR and DONE, held in a registered state vector.
REQ-013 ready SHALL be 1 in IDLE and DONE, and 0 in SYNC, DATA and PAR.
REQ-014 Accept: start=1 and ready=1 on an edge SHALL latch din into a shift register, clear the bit counter and enter SYNC.
REQ-015 start while ready=0 SHALL be ignored, with no queuing and no effect on the current frame.
REQ-016 SYNC SHALL last 4 cycles, driving SYNC[3], SYNC[2], SYNC[1], SYNC[0] in order; the first bit appears in the cycle after acceptance (latency 1).
REQ-017 DATA SHALL last DATA_W cycles, driving the latched payload MSB first.
REQ-018 PAR (PARITY_EN=1 only) SHALL last 1 cycle with out = XOR of all latched payload bits (even parity); with PARITY_EN=0, DATA goes directly to DONE.
REQ-019 DONE SHALL last exactly 1 cycle with done=1 and out=0, then go to IDLE unless a start is accepted on that edge, in which case it goes to SYNC.
REQ-020 out SHALL be 0 and busy 0 in IDLE and DONE; busy SHALL be 1 in SYNC, DATA and PAR.
REQ-021 out and busy SHALL come directly from registers or from state decode only, with no combinational path from start or din.
REQ-022 Minimum frame period (start to start) SHALL be 4+DATA_W+PARITY_EN+1 cycles; back-to-back frames SHALL be seamless apart from the single DONE cycle.
REQ-023 din changes after acceptance SHALL NOT alter the frame in flight.
REQ-024 The bit counter SHALL be wide enough for the larger of 4 and DATA_W without wrap, and SHALL reset to 0 on each state change.
REQ-025 Unreachable state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for a clock, force state=IDLE, out=0, busy=0, done=0, ready=1, and clear the counter and shift register.
REQ-027 A reset asserted mid-frame SHALL abort the frame with no done pulse; the first edge after rst_n rises SHALL be able to accept a start.

Verification
REQ-028 Defaults, din=8'hA5, single start -> out over 13 cycles = 1,0,0,1, 1,0,1,0,0,1,0,1, 0; busy high for those 13 cycles; done high in cycle 14; ready low in cycles 1-13.
REQ-029 din=8'h01 -> payload 0000_0001, parity bit 1; din=8'h00 -> parity bit 0.
REQ-030 start held high continuously with din=8'hFF, then 8'h3C -> frames repeat every 14 cycles, each parity bit 0, one done per frame, and no extra idle cycle.
REQ-031 start pulsed during the DATA phase of a frame -> the pulse is ignored, the current frame completes unchanged, and no second frame is sent.
REQ-032 rst_n asserted during payload bit 3, asynchronously between edges -> out, busy and done go to 0 at once and ready to 1; no done pulse; a new start after release sends a full frame.
REQ-033 PARITY_EN=0, DATA_W=4, din=4'b0110 -> out = 1,0,0,1,0,1,1,0, then done on the next cycle; frame period 9 cycles.

Source files
------------

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: 4-bit sync marker, MSB-first payload,
// optional even-parity bit, then a one-cycle done marker.
module seq_frame_tx #(
    parameter int          DATA_W    = 8,
    parameter logic [3:0]  SYNC      = 4'b1001,
    parameter bit          PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              out,
    output logic              busy,
    output logic              done
);

    localparam int MAXN = (DATA_W > 4) ? DATA_W : 4;
    localparam int CW   = $clog2(MAXN);

    localparam logic [CW-1:0] SYNC_LAST = CW'(3);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_DATA = 3'd2,
        S_PAR  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              par_q, par_d;
    logic              accept;

    assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign accept = start && ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        sr_d    = sr_q;
        par_d   = par_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
            end
            S_SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                sr_d = sr_q << 1;
                if (cnt_q == DATA_LAST) begin
                    state_d = PARITY_EN ? S_PAR : S_DONE;
                    cnt_d   = '0;
                end
            end
            S_PAR: begin
                state_d = S_DONE;
                cnt_d   = '0;
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Accept overrides the IDLE/DONE transition; parity is taken from din now
        if (accept) begin
            state_d = S_SYNC;
            cnt_d   = '0;
            sr_d    = din;
            par_d   = ^din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        out  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            S_SYNC: begin
                out  = SYNC[~cnt_q[1:0]];
                busy = 1'b1;
            end
            S_DATA: begin
                out  = sr_q[DATA_W-1];
                busy = 1'b1;
            end
            S_PAR: begin
                out  = par_q;
                busy = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                out  = 1'b0;
            end
        endcase
    end

endmodule
